// File: rtl/score_pkg.sv
// Shared definitions for the score keeper: FSM states, winner codes,
// default winning score and a small integer-to-BCD helper.
package score_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10,
      WIN_DRAW = 2'b11
   } winner_t;

   localparam int unsigned WIN_SCORE_DEFAULT = 11;

   function automatic logic [7:0] to_bcd(input int unsigned v);
      return {4'((v / 10) % 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD up-counter (00..99) with synchronous clear and increment.
module bcd_counter_2digit (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] units,
   output logic [3:0] tens
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         units <= '0;
         tens  <= '0;
      end else if (clr) begin
         units <= '0;
         tens  <= '0;
      end else if (inc && !(tens == 4'd9 && units == 4'd9)) begin
         // saturate at 99 so a digit can never leave the BCD range
         if (units == 4'd9) begin
            units <= '0;
            tens  <= tens + 4'd1;
         end else begin
            units <= units + 4'd1;
         end
      end
   end

endmodule

// File: rtl/score_keeper.sv
// Two-player BCD score keeper: edge-detected controls, IDLE/PLAY/OVER FSM,
// winner detection on the edge a score reaches WIN_SCORE.
module score_keeper
   import score_pkg::*;
#(
   parameter int unsigned WIN_SCORE = WIN_SCORE_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       p1_point,
   input  logic       p2_point,
   output logic [3:0] player1_unit,
   output logic [3:0] player1_tens,
   output logic [3:0] player2_unit,
   output logic [3:0] player2_tens,
   output logic       playing,
   output logic       game_over,
   output logic [1:0] winner
);

   localparam logic [7:0] PRE_WIN = to_bcd(WIN_SCORE - 1);

   state_t  state, state_next;
   winner_t win_q, win_next;
   logic    start_q, p1_q, p2_q;
   logic    start_ev, p1_ev, p2_ev;
   logic    clr, inc1, inc2, hit1, hit2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_q <= 1'b0;
         p1_q    <= 1'b0;
         p2_q    <= 1'b0;
         state   <= IDLE;
         win_q   <= WIN_NONE;
      end else begin
         start_q <= start;
         p1_q    <= p1_point;
         p2_q    <= p2_point;
         state   <= state_next;
         win_q   <= win_next;
      end
   end

   assign start_ev = start & ~start_q;
   assign p1_ev    = p1_point & ~p1_q;
   assign p2_ev    = p2_point & ~p2_q;

   // a score hits WIN_SCORE on this edge when it currently sits one below it
   assign hit1 = p1_ev && ({player1_tens, player1_unit} == PRE_WIN);
   assign hit2 = p2_ev && ({player2_tens, player2_unit} == PRE_WIN);

   always_comb begin
      state_next = state;
      win_next   = win_q;
      clr        = 1'b0;
      inc1       = 1'b0;
      inc2       = 1'b0;
      case (state)
         IDLE, OVER: begin
            if (start_ev) begin
               clr        = 1'b1;
               win_next   = WIN_NONE;
               state_next = PLAY;
            end
         end
         PLAY: begin
            if (start_ev) begin
               clr = 1'b1;
            end else begin
               inc1 = p1_ev;
               inc2 = p2_ev;
               if (hit1 || hit2) begin
                  state_next = OVER;
                  win_next   = winner_t'({hit2, hit1});
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   bcd_counter_2digit u_p1 (
      .clk   (clk),
      .reset (reset),
      .inc   (inc1),
      .clr   (clr),
      .units (player1_unit),
      .tens  (player1_tens)
   );

   bcd_counter_2digit u_p2 (
      .clk   (clk),
      .reset (reset),
      .inc   (inc2),
      .clr   (clr),
      .units (player2_unit),
      .tens  (player2_tens)
   );

   assign playing   = (state == PLAY);
   assign game_over = (state == OVER);
   assign winner    = win_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: one instance at WIN_SCORE=11, one at 15,
// sharing stimulus; outputs packed as {p1t,p1u,p2t,p2u,playing,game_over,winner}.
module tb_score_keeper;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       p1_point = 1'b0;
   logic       p2_point = 1'b0;
   logic [3:0] a_p1u, a_p1t, a_p2u, a_p2t, b_p1u, b_p1t, b_p2u, b_p2t;
   logic       a_play, a_over, b_play, b_over;
   logic [1:0] a_win, b_win;
   logic [19:0] obs11, obs15;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   score_keeper #(.WIN_SCORE(11)) dut11 (
      .clk(clk), .reset(reset), .start(start), .p1_point(p1_point), .p2_point(p2_point),
      .player1_unit(a_p1u), .player1_tens(a_p1t), .player2_unit(a_p2u), .player2_tens(a_p2t),
      .playing(a_play), .game_over(a_over), .winner(a_win)
   );

   score_keeper #(.WIN_SCORE(15)) dut15 (
      .clk(clk), .reset(reset), .start(start), .p1_point(p1_point), .p2_point(p2_point),
      .player1_unit(b_p1u), .player1_tens(b_p1t), .player2_unit(b_p2u), .player2_tens(b_p2t),
      .playing(b_play), .game_over(b_over), .winner(b_win)
   );

   assign obs11 = {a_p1t, a_p1u, a_p2t, a_p2u, a_play, a_over, a_win};
   assign obs15 = {b_p1t, b_p1u, b_p2t, b_p2u, b_play, b_over, b_win};

   localparam logic [19:0] ALL_ZERO  = 20'h0;
   localparam logic [19:0] PLAY_ZERO = {16'h0, 1'b1, 1'b0, 2'b00};

   task automatic pulse(input logic a, input logic b);
      @(negedge clk);
      p1_point = a;
      p2_point = b;
      @(negedge clk);
      p1_point = 1'b0;
      p2_point = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if (obs11 !== ALL_ZERO) begin
         bad++; $display("FAIL reset_state got=%h exp=%h", obs11, ALL_ZERO);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (3) pulse(1'b1, 1'b0);
      total++;
      if (obs11 !== ALL_ZERO) begin
         bad++; $display("FAIL idle_ignore11 got=%h exp=%h", obs11, ALL_ZERO);
      end
      total++;
      if (obs15 !== ALL_ZERO) begin
         bad++; $display("FAIL idle_ignore15 got=%h exp=%h", obs15, ALL_ZERO);
      end
   endtask

   task automatic test_count();
      pulse_start();
      total++;
      if (obs15 !== PLAY_ZERO) begin
         bad++; $display("FAIL start_play got=%h exp=%h", obs15, PLAY_ZERO);
      end
      repeat (9) pulse(1'b1, 1'b0);
      total++;
      if (obs15 !== {4'd0, 4'd9, 8'h00, 1'b1, 1'b0, 2'b00}) begin
         bad++; $display("FAIL count9 got=%h exp=%h", obs15, {4'd0, 4'd9, 8'h00, 4'b1000});
      end
      pulse(1'b1, 1'b0);
      total++;
      if (obs15 !== {4'd1, 4'd0, 8'h00, 1'b1, 1'b0, 2'b00}) begin
         bad++; $display("FAIL carry10 got=%h exp=%h", obs15, {4'd1, 4'd0, 8'h00, 4'b1000});
      end
      pulse(1'b1, 1'b0);
      total++;
      if (obs11 !== {4'd1, 4'd1, 8'h00, 1'b0, 1'b1, 2'b01}) begin
         bad++; $display("FAIL p1_win got=%h exp=%h", obs11, {4'd1, 4'd1, 8'h00, 4'b0101});
      end
      pulse(1'b1, 1'b0);
      total++;
      if (obs15 !== {4'd1, 4'd2, 8'h00, 1'b1, 1'b0, 2'b00}) begin
         bad++; $display("FAIL count12 got=%h exp=%h", obs15, {4'd1, 4'd2, 8'h00, 4'b1000});
      end
      total++;
      if (obs11 !== {4'd1, 4'd1, 8'h00, 1'b0, 1'b1, 2'b01}) begin
         bad++; $display("FAIL over_frozen1 got=%h exp=%h", obs11, {4'd1, 4'd1, 8'h00, 4'b0101});
      end
   endtask

   task automatic test_p2_win();
      pulse_start();
      total++;
      if (obs11 !== PLAY_ZERO) begin
         bad++; $display("FAIL restart_from_over got=%h exp=%h", obs11, PLAY_ZERO);
      end
      repeat (10) pulse(1'b0, 1'b1);
      total++;
      if (obs11 !== {8'h00, 4'd1, 4'd0, 1'b1, 1'b0, 2'b00}) begin
         bad++; $display("FAIL p2_at10 got=%h exp=%h", obs11, {8'h00, 4'd1, 4'd0, 4'b1000});
      end
      pulse(1'b0, 1'b1);
      total++;
      if (obs11 !== {8'h00, 4'd1, 4'd1, 1'b0, 1'b1, 2'b10}) begin
         bad++; $display("FAIL p2_win got=%h exp=%h", obs11, {8'h00, 4'd1, 4'd1, 4'b0110});
      end
      pulse(1'b0, 1'b1);
      total++;
      if (obs11 !== {8'h00, 4'd1, 4'd1, 1'b0, 1'b1, 2'b10}) begin
         bad++; $display("FAIL over_frozen2 got=%h exp=%h", obs11, {8'h00, 4'd1, 4'd1, 4'b0110});
      end
      total++;
      if (obs15 !== {8'h00, 4'd1, 4'd2, 1'b1, 1'b0, 2'b00}) begin
         bad++; $display("FAIL p2_count12 got=%h exp=%h", obs15, {8'h00, 4'd1, 4'd2, 4'b1000});
      end
   endtask

   task automatic test_draw();
      pulse_start();
      repeat (10) pulse(1'b1, 1'b1);
      total++;
      if (obs11 !== {4'd1, 4'd0, 4'd1, 4'd0, 1'b1, 1'b0, 2'b00}) begin
         bad++; $display("FAIL both10 got=%h exp=%h", obs11, {16'h1010, 4'b1000});
      end
      pulse(1'b1, 1'b1);
      total++;
      if (obs11 !== {4'd1, 4'd1, 4'd1, 4'd1, 1'b0, 1'b1, 2'b11}) begin
         bad++; $display("FAIL draw got=%h exp=%h", obs11, {16'h1111, 4'b0111});
      end
   endtask

   task automatic test_held();
      pulse_start();
      @(negedge clk);
      p1_point = 1'b1;
      repeat (50) @(negedge clk);
      p1_point = 1'b0;
      @(negedge clk);
      total++;
      if (obs11 !== {4'd0, 4'd1, 8'h00, 1'b1, 1'b0, 2'b00}) begin
         bad++; $display("FAIL held_once got=%h exp=%h", obs11, {16'h0100, 4'b1000});
      end
      start = 1'b1;
      p1_point = 1'b1;
      @(negedge clk);
      total++;
      if (obs11 !== PLAY_ZERO) begin
         bad++; $display("FAIL start_beats_point got=%h exp=%h", obs11, PLAY_ZERO);
      end
      repeat (5) @(negedge clk);
      start = 1'b0;
      p1_point = 1'b0;
      pulse(1'b1, 1'b0);
      total++;
      if (obs11 !== {4'd0, 4'd1, 8'h00, 1'b1, 1'b0, 2'b00}) begin
         bad++; $display("FAIL held_start_once got=%h exp=%h", obs11, {16'h0100, 4'b1000});
      end
   endtask

   task automatic test_reset_mid();
      pulse_start();
      repeat (3) pulse(1'b1, 1'b1);
      repeat (2) pulse(1'b1, 1'b0);
      total++;
      if (obs11 !== {4'd0, 4'd5, 4'd0, 4'd3, 1'b1, 1'b0, 2'b00}) begin
         bad++; $display("FAIL score5_3 got=%h exp=%h", obs11, {16'h0503, 4'b1000});
      end
      #2;
      reset = 1'b0;
      p1_point = 1'b1;
      #1;
      total++;
      if (obs11 !== ALL_ZERO) begin
         bad++; $display("FAIL async_reset got=%h exp=%h", obs11, ALL_ZERO);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      p1_point = 1'b0;
      total++;
      if (obs11 !== ALL_ZERO) begin
         bad++; $display("FAIL idle_after_reset got=%h exp=%h", obs11, ALL_ZERO);
      end
      pulse_start();
      pulse(1'b1, 1'b0);
      total++;
      if (obs11 !== {4'd0, 4'd1, 8'h00, 1'b1, 1'b0, 2'b00}) begin
         bad++; $display("FAIL play_after_reset got=%h exp=%h", obs11, {16'h0100, 4'b1000});
      end
   endtask

   initial begin
      test_reset();
      test_count();
      test_p2_win();
      test_draw();
      test_held();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
